// File: rtl/noc_demux_route_pkg.sv
// Shared types for the router-input demux route controller: FSM states and
// the route-table entry layout.
package noc_demux_route_pkg;

  // Widest channel index a route entry can hold; CH_WIDTH must not exceed it.
  localparam int MAX_CH_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } state_e;

  typedef struct packed {
    logic                    enable;
    logic [MAX_CH_WIDTH-1:0] channel;
  } route_entry_t;

endpackage

// File: rtl/noc_demux_route_controller_if.sv
// Flit-stream, select/drop and route-table configuration signals between the
// demux datapath and its route controller.
interface noc_demux_route_controller_if #(
    parameter int CHANNELS   = 5,
    parameter int DEST_WIDTH = 4,
    parameter int CH_WIDTH   = 3
);
    logic                  i_flit_valid;
    logic                  i_flit_ready;
    logic                  i_flit_head;
    logic                  i_flit_tail;
    logic [DEST_WIDTH-1:0] i_flit_destination;
    logic [CHANNELS-1:0]   o_select;
    logic                  o_drop;
    logic                  i_cfg_valid;
    logic [DEST_WIDTH-1:0] i_cfg_destination;
    logic [CH_WIDTH-1:0]   i_cfg_channel;
    logic                  i_cfg_enable;

    modport slave (
        input  i_flit_valid, i_flit_ready, i_flit_head, i_flit_tail, i_flit_destination,
        input  i_cfg_valid, i_cfg_destination, i_cfg_channel, i_cfg_enable,
        output o_select, o_drop
    );

    modport master (
        output i_flit_valid, i_flit_ready, i_flit_head, i_flit_tail, i_flit_destination,
        output i_cfg_valid, i_cfg_destination, i_cfg_channel, i_cfg_enable,
        input  o_select, o_drop
    );
endinterface

// File: rtl/noc_route_table.sv
// Destination -> channel route table: one synchronous write port, one
// asynchronous read port, every entry invalid after reset.
module noc_route_table
    import noc_demux_route_pkg::*;
#(
    parameter int DESTINATIONS = 16,
    parameter int DEST_WIDTH   = $clog2(DESTINATIONS),
    parameter int CH_WIDTH     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEST_WIDTH-1:0] wr_addr,
    input  logic [CH_WIDTH-1:0]   wr_channel,
    input  logic                  wr_enable,
    input  logic [DEST_WIDTH-1:0] rd_addr,
    output route_entry_t          rd_entry
);

    route_entry_t route_q [DESTINATIONS];
    route_entry_t route_d [DESTINATIONS];

    // NOTE: every always_comb output is assigned a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        route_d = route_q;
        if (wr_en && (int'(wr_addr) < DESTINATIONS)) begin
            route_d[wr_addr] = '{enable: wr_enable, channel: MAX_CH_WIDTH'(wr_channel)};
        end
    end

    // NOTE: the table is small flops, not RAM, so it is cleared by reset; entry validity must be known from the first cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DESTINATIONS; i++) begin
                route_q[i] <= '0;
            end
        end else begin
            route_q <= route_d;
        end
    end

    // The read sees the registered table, so a same-cycle write returns the old entry.
    assign rd_entry = (int'(rd_addr) < DESTINATIONS) ? route_q[rd_addr] : '0;

endmodule

// File: rtl/noc_demux_route_controller.sv
// Route controller for a router-input flit demux: looks up the head flit's
// destination, holds the one-hot select for the packet, drops unroutable packets.
module noc_demux_route_controller
    import noc_demux_route_pkg::*;
#(
    parameter int CHANNELS     = 5,
    parameter int DESTINATIONS = 16,
    parameter int DEST_WIDTH   = $clog2(DESTINATIONS),
    parameter int CH_WIDTH     = $clog2(CHANNELS),
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    noc_demux_route_controller_if.slave  flit_if,
    output logic                         o_busy,
    output logic [COUNT_WIDTH-1:0]       o_drop_count
);

    route_entry_t lookup;
    logic         route_ok;

    state_e                 state_q, state_d;
    logic [CHANNELS-1:0]    select_q, select_d;
    logic                   drop_q, drop_d;
    logic                   busy_q, busy_d;
    logic [COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

    noc_route_table #(
        .DESTINATIONS (DESTINATIONS),
        .DEST_WIDTH   (DEST_WIDTH),
        .CH_WIDTH     (CH_WIDTH)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (flit_if.i_cfg_valid),
        .wr_addr    (flit_if.i_cfg_destination),
        .wr_channel (flit_if.i_cfg_channel),
        .wr_enable  (flit_if.i_cfg_enable),
        .rd_addr    (flit_if.i_flit_destination),
        .rd_entry   (lookup)
    );

    // An entry pointing past the last demux output is as unroutable as an invalid one.
    assign route_ok = lookup.enable && (int'(lookup.channel) < CHANNELS);

    always_comb begin
        state_d      = state_q;
        select_d     = select_q;
        drop_d       = drop_q;
        drop_count_d = drop_count_q;
        case (state_q)
            ST_IDLE: begin
                if (flit_if.i_flit_valid) begin
                    if (flit_if.i_flit_head && route_ok) begin
                        state_d  = ST_ACTIVE;
                        select_d = CHANNELS'(1) << lookup.channel;
                    end else begin
                        state_d = ST_DROP;
                        drop_d  = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (flit_if.i_flit_valid && flit_if.i_flit_ready && flit_if.i_flit_tail) begin
                    state_d  = ST_IDLE;
                    select_d = '0;
                end
            end
            ST_DROP: begin
                // Upstream ready is forced while dropping, so any valid tail ends the packet.
                if (flit_if.i_flit_valid && flit_if.i_flit_tail) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                    if (!(&drop_count_q)) begin
                        drop_count_d = drop_count_q + COUNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                select_d = '0;
                drop_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            select_q     <= '0;
            drop_q       <= 1'b0;
            busy_q       <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            select_q     <= select_d;
            drop_q       <= drop_d;
            busy_q       <= busy_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign flit_if.o_select = select_q;
    assign flit_if.o_drop   = drop_q;
    assign o_busy           = busy_q;
    assign o_drop_count     = drop_count_q;

endmodule

// File: tb/tb_noc_demux_route_controller.sv
// Bench for noc_demux_route_controller: directed scenarios then random packet
// traffic, all checked cycle by cycle against a packet-level reference model.
module tb_noc_demux_route_controller;

    localparam int CHANNELS   = 5;
    localparam int DEST_WIDTH = 4;
    localparam int CH_WIDTH   = 3;
    localparam int SAT_WIDTH  = 3;
    localparam int SAT_MAX    = (1 << SAT_WIDTH) - 1;
    localparam int M_IDLE     = -1;
    localparam int M_DROP     = -2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_demux_route_controller_if #(.CHANNELS(CHANNELS), .DEST_WIDTH(DEST_WIDTH), .CH_WIDTH(CH_WIDTH)) bus ();
    noc_demux_route_controller_if #(.CHANNELS(CHANNELS), .DEST_WIDTH(DEST_WIDTH), .CH_WIDTH(CH_WIDTH)) bus_s ();

    logic                 busy, busy_s;
    logic [15:0]          drop_count;
    logic [SAT_WIDTH-1:0] drop_count_s;
    logic [CHANNELS-1:0]  ds_ready;

    // Demux ready is the OR of the downstream readies on the selected channel.
    assign bus.i_flit_ready   = |(bus.o_select & ds_ready);
    assign bus_s.i_flit_ready = |(bus_s.o_select & ds_ready);

    // The narrow-counter instance sees exactly the same stimulus.
    assign bus_s.i_flit_valid       = bus.i_flit_valid;
    assign bus_s.i_flit_head        = bus.i_flit_head;
    assign bus_s.i_flit_tail        = bus.i_flit_tail;
    assign bus_s.i_flit_destination = bus.i_flit_destination;
    assign bus_s.i_cfg_valid        = bus.i_cfg_valid;
    assign bus_s.i_cfg_destination  = bus.i_cfg_destination;
    assign bus_s.i_cfg_channel      = bus.i_cfg_channel;
    assign bus_s.i_cfg_enable       = bus.i_cfg_enable;

    noc_demux_route_controller u_dut (
        .clk          (clk),
        .rst          (rst),
        .flit_if      (bus.slave),
        .o_busy       (busy),
        .o_drop_count (drop_count)
    );

    noc_demux_route_controller #(.COUNT_WIDTH(SAT_WIDTH)) u_dut_sat (
        .clk          (clk),
        .rst          (rst),
        .flit_if      (bus_s.slave),
        .o_busy       (busy_s),
        .o_drop_count (drop_count_s)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model: which packet is in flight (a channel, a drop, or none) plus the table contents.
    bit m_en [16];
    int m_ch [16];
    int m_cur;
    int m_drops;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_en[i] = 1'b0;
            m_ch[i] = 0;
        end
        m_cur   = M_IDLE;
        m_drops = 0;
    endtask

    int          ds_mode  = 1;      // 0 random, 1 all ready, 2 none ready
    bit          rand_cfg = 1'b0;
    bit          last_xfer;
    int          cycles = 0;
    int          n_drop_cycles;
    logic [31:0] sel_hist[$];

    task automatic set_ds_ready();
        case (ds_mode)
            0:       ds_ready = CHANNELS'($urandom);
            1:       ds_ready = '1;
            default: ds_ready = '0;
        endcase
    endtask

    // One clock: sample inputs mid-cycle, advance model at the edge, compare just after it.
    task automatic step();
        logic v, h, t, rdy, drp, cv, ce;
        logic [DEST_WIDTH-1:0] d, cd;
        logic [CH_WIDTH-1:0]   cc;
        int exp_sel;
        @(negedge clk);
        v   = bus.i_flit_valid;
        h   = bus.i_flit_head;
        t   = bus.i_flit_tail;
        d   = bus.i_flit_destination;
        rdy = bus.i_flit_ready;
        drp = bus.o_drop;
        cv  = bus.i_cfg_valid;
        cd  = bus.i_cfg_destination;
        cc  = bus.i_cfg_channel;
        ce  = bus.i_cfg_enable;
        last_xfer = v && (rdy || drp);
        @(posedge clk);
        cycles++;
        if (m_cur == M_IDLE) begin
            if (v) m_cur = (h && m_en[d] && (m_ch[d] < CHANNELS)) ? m_ch[d] : M_DROP;
        end else if (m_cur == M_DROP) begin
            if (v && t) begin
                m_cur = M_IDLE;
                m_drops++;
            end
        end else if (v && rdy && t) begin
            m_cur = M_IDLE;
        end
        if (cv) begin
            m_en[cd] = ce;
            m_ch[cd] = int'(cc);
        end
        #1;
        exp_sel = (m_cur >= 0) ? (1 << m_cur) : 0;
        expect_eq("select",       bus.o_select,   exp_sel);
        expect_eq("drop",         bus.o_drop,     m_cur == M_DROP);
        expect_eq("busy",         busy,           m_cur != M_IDLE);
        expect_eq("drop_count",   drop_count,     (m_drops > 16'hFFFF) ? 16'hFFFF : m_drops);
        expect_eq("select_sat",   bus_s.o_select, exp_sel);
        expect_eq("drop_count_s", drop_count_s,   (m_drops > SAT_MAX) ? SAT_MAX : m_drops);
        sel_hist.push_back(32'(bus.o_select));
        if (bus.o_drop) n_drop_cycles++;
        bus.i_cfg_valid = 1'b0;
        if (rand_cfg && ($urandom_range(5) == 0)) begin
            bus.i_cfg_valid       = 1'b1;
            bus.i_cfg_destination = DEST_WIDTH'($urandom);
            bus.i_cfg_channel     = CH_WIDTH'($urandom_range(7));
            bus.i_cfg_enable      = ($urandom_range(3) != 0);
        end
        set_ds_ready();
    endtask

    task automatic cfg_now(input int dest, input int ch, input bit en);
        bus.i_cfg_valid       = 1'b1;
        bus.i_cfg_destination = DEST_WIDTH'(dest);
        bus.i_cfg_channel     = CH_WIDTH'(ch);
        bus.i_cfg_enable      = en;
    endtask

    task automatic send_flit(input bit h, input bit t, input int dest, input int rate);
        int n = 0;
        bus.i_flit_head        = h;
        bus.i_flit_tail        = t;
        bus.i_flit_destination = DEST_WIDTH'(dest);
        do begin
            bus.i_flit_valid = ($urandom_range(99) < rate);
            step();
            n++;
        end while (!last_xfer && n < 200);
        bus.i_flit_valid = 1'b0;
        if (!last_xfer) expect_eq("xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_packet(input int dest, input int len, input int rate, input bit headless);
        for (int i = 0; i < len; i++) begin
            send_flit((i == 0) ? !headless : ($urandom_range(7) == 0), i == len - 1,
                      (i == 0) ? dest : int'($urandom_range(15)), rate);
        end
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        bus.i_flit_valid = 1'b0;
        bus.i_flit_head = 1'b0;
        bus.i_flit_tail = 1'b0;
        bus.i_flit_destination = '0;
        bus.i_cfg_valid = 1'b0;
        bus.i_cfg_destination = '0;
        bus.i_cfg_channel = '0;
        bus.i_cfg_enable = 1'b0;
        ds_ready = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_select", bus.o_select, 32'd0);
        expect_eq("rst_drop",   bus.o_drop,   32'd0);
        expect_eq("rst_busy",   busy,         32'd0);
        expect_eq("rst_count",  drop_count,   32'd0);
        rst = 1'b0;

        // 4-flit packet to dest 3 on channel 2, always ready.
        cfg_now(3, 2, 1'b1);
        step();
        c0 = cycles;
        send_flit(1'b1, 1'b0, 3, 100);
        expect_eq("pkt4_sel_head", bus.o_select, 32'b00100);
        send_flit(1'b0, 1'b0, 0, 100);
        send_flit(1'b0, 1'b0, 0, 100);
        expect_eq("pkt4_sel_mid", bus.o_select, 32'b00100);
        send_flit(1'b0, 1'b1, 0, 100);
        expect_eq("pkt4_cycles", cycles - c0, 32'd5);
        expect_eq("pkt4_sel_end", bus.o_select, 32'd0);

        // Back-to-back single-flit packets: channel 0 then channel 4.
        cfg_now(1, 0, 1'b1);
        step();
        cfg_now(4, 4, 1'b1);
        step();
        sel_hist.delete();
        send_flit(1'b1, 1'b1, 1, 100);
        send_flit(1'b1, 1'b1, 4, 100);
        expect_eq("b2b_sel0", sel_hist[0], 32'b00001);
        expect_eq("b2b_sel1", sel_hist[1], 32'b00000);
        expect_eq("b2b_sel2", sel_hist[2], 32'b10000);

        // 3-flit packet to unprogrammed dest 7 is dropped.
        expect_eq("drop_cnt_before", drop_count, 32'd0);
        n_drop_cycles = 0;
        send_packet(7, 3, 100, 1'b0);
        expect_eq("drop_cycles", n_drop_cycles, 32'd3);
        expect_eq("drop_cnt_after", drop_count, 32'd1);

        // Channel 1 stalled mid-packet for 10 cycles.
        cfg_now(2, 1, 1'b1);
        step();
        send_flit(1'b1, 1'b0, 2, 100);
        ds_mode = 2;
        ds_ready = '0;
        bus.i_flit_head = 1'b0;
        bus.i_flit_tail = 1'b0;
        bus.i_flit_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_eq("stall_sel",  bus.o_select, 32'b00010);
            expect_eq("stall_busy", busy, 32'd1);
            expect_eq("stall_xfer", last_xfer, 32'd0);
        end
        ds_mode = 1;
        ds_ready = '1;
        send_flit(1'b0, 1'b1, 0, 100);

        // Rewriting a route mid-packet only affects the next packet.
        send_flit(1'b1, 1'b0, 3, 100);
        cfg_now(3, 0, 1'b1);
        send_flit(1'b0, 1'b0, 0, 100);
        expect_eq("rewrite_cur", bus.o_select, 32'b00100);
        send_flit(1'b0, 1'b1, 0, 100);
        send_flit(1'b1, 1'b0, 3, 100);
        expect_eq("rewrite_next", bus.o_select, 32'b00001);

        // Asynchronous reset in the middle of that packet.
        #2;
        rst = 1'b1;
        #1;
        expect_eq("midrst_select", bus.o_select, 32'd0);
        expect_eq("midrst_drop",   bus.o_drop,   32'd0);
        expect_eq("midrst_busy",   busy,         32'd0);
        expect_eq("midrst_count",  drop_count,   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_packet(3, 2, 100, 1'b0);
        expect_eq("post_rst_drop", drop_count, 32'd1);

        // Saturation of the narrow counter.
        for (int i = 0; i < 10; i++) send_packet(9, 1, 100, 1'b0);
        expect_eq("sat_count_s", drop_count_s, SAT_MAX);
        expect_eq("sat_count",   drop_count,   32'd11);

        // Random traffic with background table writes.
        rand_cfg = 1'b1;
        ds_mode  = 0;
        for (int p = 0; p < 300; p++) begin
            send_packet($urandom_range(15), $urandom_range(1, 5), $urandom_range(60, 100),
                        $urandom_range(15) == 0);
            repeat ($urandom_range(2)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
